lcd_panel_responder: RTL and testbench
======================================

LCD_PANEL_RESPONDER -- requirements
Module: lcd_panel_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000, giving the busy time per accepted command or data write (40 us at 50 MHz).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 76500, giving the busy time for Clear Display; legal values are >= 32.
REQ-003 SHALL have port clk, input, 1 bit: single clock, 50 MHz, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports RS, RW and E, each input, 1 bit: register select, read/write and enable strobe from the LCD host.
REQ-006 SHALL have port Data_Bus, input, 8 bits: host write data D7-D0.
REQ-007 SHALL have port lcd_data_out, output, 8 bits: read data returned to the host.
REQ-008 SHALL have port lcd_data_oe, output, 1 bit: high when the block drives read data.
REQ-009 SHALL have port busy, output, 1 bit: busy flag (BF).
REQ-010 SHALL have port initialized, output, 1 bit: high once a Function Set has been accepted.
REQ-011 SHALL have ports display_on, cursor_on and blink_on, each output, 1 bit: the D, C and B flags.
REQ-012 SHALL have port addr_counter, output, 7 bits: DDRAM address counter (AC).
REQ-013 SHALL have port rd_addr, input, 5 bits: debug read index, {line, column[3:0]}.
REQ-014 SHALL have port rd_char, output, 8 bits: DDRAM[rd_addr], registered, 1-cycle latency.
REQ-015 SHALL have port protocol_err, output, 1 bit: one-cycle pulse on any rejected strobe.

Function
REQ-016 SHALL register E each cycle; rise = E & ~E_d1, fall = ~E & E_d1.
REQ-017 SHALL capture RS, RW and Data_Bus on the rise cycle, and execute the captured access on the fall cycle.
REQ-018 SHALL use FSM states S_UNINIT, S_READY, S_BUSY and S_CLEARING.
REQ-019 In S_UNINIT, SHALL accept only Function Set (RS=0, RW=0, 001x_xxxx); it sets initialized and enters S_BUSY; any other write pulses protocol_err.
REQ-020 In S_READY, SHALL execute a write and enter S_BUSY for BUSY_CYCLES, or enter S_CLEARING for Clear; after the count it returns to S_READY.
REQ-021 SHALL hold busy=1 in S_BUSY and S_CLEARING, and busy=0 otherwise.
REQ-022 SHALL ignore a write strobe whose fall occurs while busy=1, with no state change and a protocol_err pulse.
REQ-023 For Clear (0x01), SHALL write 0x20 to the 32 DDRAM locations at one per cycle over the first 32 cycles of S_CLEARING, set AC=0x00 and set I/D=1.
REQ-024 For Return Home (0000_001x), SHALL set AC=0x00.
REQ-025 For Entry Mode (0000_01xx), SHALL set I/D=bit1; the S bit is ignored.
REQ-026 For Display Control (0000_1dcb), SHALL set display_on, cursor_on and blink_on.
REQ-027 For Cursor/Shift (0001_xxxx), SHALL move AC right if bit2=1 and left if bit2=0 when bit3=0; bit3=1 (display shift) is a no-op that still goes busy.
REQ-028 For Function Set (001x_xxxx) after initialization, SHALL accept it as a no-op that still goes busy.
REQ-029 For CGRAM Address (01xx_xxxx), SHALL accept it as a no-op that still goes busy.
REQ-030 For Set DDRAM Address (1aaa_aaaa), SHALL load AC=aaaaaaa if it is in 0x00-0x0F or 0x40-0x4F; otherwise it pulses protocol_err, leaves AC unchanged and does not go busy.
REQ-031 For a data write (RS=1, RW=0) in S_READY, SHALL write DDRAM[{AC[6],AC[3:0]}]=Data_Bus, then step AC.
REQ-032 AC step SHALL be: increment wraps 0x0F->0x40 and 0x4F->0x00; decrement wraps 0x00->0x4F and 0x40->0x0F.
REQ-033 For RW=1, SHALL assert lcd_data_oe during every cycle with E=1.
REQ-034 For RS=0 read, SHALL set lcd_data_out={busy, AC}; this is legal in any state and never an error.
REQ-035 For RS=1 read in S_READY, SHALL set lcd_data_out=DDRAM at AC (captured on rise) and step AC on fall with no busy time; if busy, it returns 0x00 and pulses protocol_err.
REQ-036 When RW=0, SHALL hold lcd_data_oe=0 and lcd_data_out=0x00.
REQ-037 If a rise and a busy-count expiry occur in the same cycle, SHALL treat the strobe by its fall cycle only.
REQ-038 SHALL apply a fall with no preceding captured rise as no action.

Reset
REQ-039 On reset_n=0, SHALL immediately and asynchronously enter S_UNINIT.
REQ-040 On reset, SHALL set busy=0, initialized=0, display_on=0, cursor_on=0, blink_on=0, AC=0x00, I/D=1, lcd_data_oe=0, lcd_data_out=0x00, rd_char=0x00, protocol_err=0, clear E_d1 and the capture registers, and zero the busy counter.
REQ-041 SHALL leave DDRAM contents unchanged by reset; they are undefined until the first Clear.
REQ-042 If reset occurs mid-clear, SHALL abort the fill, so the host re-initializes.

Verification (bench overrides BUSY_CYCLES=4, CLEAR_CYCLES=40)
REQ-043 Bench SHALL check: write 0x01 before any Function Set -> protocol_err pulse, initialized=0, busy=0.
REQ-044 Bench SHALL check: init sequence 0x38, 0x0C, 0x01, 0x06 with each strobe after busy falls -> initialized=1, display_on=1, cursor_on=0, AC=0x00, rd_char=0x20 at all 32 indices.
REQ-045 Bench SHALL check: data "ADD" -> rd_addr 0,1,2 read 0x41, 0x44, 0x44 and AC=0x03; a status read returns 0x03 (after busy clears) with lcd_data_oe high only while E=1.
REQ-046 Bench SHALL check: set address 0x8F, write 'X' -> index 15 reads 0x58 and AC=0x40; set 0xCF, write 'Y' -> AC=0x00.
REQ-047 Bench SHALL check: a second data strobe 2 cycles after the first -> protocol_err pulse and DDRAM and AC unchanged by it; status read meanwhile returns bit7=1.
REQ-048 Bench SHALL check: reset_n low at cycle 10 of a clear -> busy=0 and initialized=0 immediately, and a subsequent data write is rejected with protocol_err.

Source files
------------

// File: rtl/lcd_panel_responder_if.sv
// Host-side HD44780-style bus: strobe, select, write data and read-back path.
interface lcd_panel_responder_if;
    logic       RS;
    logic       RW;
    logic       E;
    logic [7:0] Data_Bus;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output RS, RW, E, Data_Bus,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  RS, RW, E, Data_Bus,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_panel_responder.sv
// Behavioural LCD controller responder: decodes host strobes, tracks busy time,
// AC, display flags and a 2x16 DDRAM with a registered debug read port.
module lcd_panel_responder #(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 76500
) (
    input  logic                        clk,
    input  logic                        reset_n,
    lcd_panel_responder_if.slave        host,
    output logic                        busy,
    output logic                        initialized,
    output logic                        display_on,
    output logic                        cursor_on,
    output logic                        blink_on,
    output logic [6:0]                  addr_counter,
    input  logic [4:0]                  rd_addr,
    output logic [7:0]                  rd_char,
    output logic                        protocol_err
);

    localparam int unsigned MAX_CYC  = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);
    localparam int unsigned FILL_LEN = 32;

    typedef enum logic [1:0] {S_UNINIT, S_READY, S_BUSY, S_CLEARING} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               e_d1;
    logic               cap_v, cap_v_d;
    logic               rs_q, rs_d, rw_q, rw_d;
    logic [7:0]         data_q, data_d;
    logic               id_q, id_d;
    logic [6:0]         ac_d;
    logic               init_d, disp_d, curs_d, blink_d;
    logic               perr_d, busy_d, oe_d;
    logic [7:0]         dout_d;
    logic               mem_we;
    logic [4:0]         mem_wa;
    logic [7:0]         mem_wd;
    logic [7:0]         ddram [32];

    logic       e_rise, e_fall;
    logic [4:0] cur_idx;

    assign e_rise  = host.E & ~e_d1;
    assign e_fall  = ~host.E & e_d1;
    assign cur_idx = {addr_counter[6], addr_counter[3:0]};

    // AC walks line 0 columns 0-15, then line 1 columns 0-15, circularly
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h0F)      r = 7'h40;
            else if (a == 7'h4F) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h4F;
            else if (a == 7'h40) r = 7'h0F;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Next-state, command decode and output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_v_d = cap_v;
        rs_d    = rs_q;
        rw_d    = rw_q;
        data_d  = data_q;
        ac_d    = addr_counter;
        id_d    = id_q;
        init_d  = initialized;
        disp_d  = display_on;
        curs_d  = cursor_on;
        blink_d = blink_on;
        perr_d  = 1'b0;
        mem_we  = 1'b0;
        mem_wa  = cur_idx;
        mem_wd  = data_q;
        oe_d    = host.E & host.RW;
        dout_d  = 8'h00;

        case (state_q)
            S_BUSY: begin
                if (cnt_q == CNT_W'(BUSY_CYCLES - 1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEARING: begin
                if (cnt_q < CNT_W'(FILL_LEN)) begin
                    mem_we = 1'b1;
                    mem_wa = cnt_q[4:0];
                    mem_wd = 8'h20;
                end
                if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (e_rise) begin
            cap_v_d = 1'b1;
            rs_d    = host.RS;
            rw_d    = host.RW;
            data_d  = host.Data_Bus;
        end else if (e_fall) begin
            cap_v_d = 1'b0;
        end

        // Execution happens on the fall; a fall without a captured rise does nothing
        if (e_fall && cap_v) begin
            if (rw_q) begin
                if (rs_q) begin
                    if (state_q == S_READY) ac_d = ac_step(addr_counter, id_q);
                    else                    perr_d = 1'b1;
                end
            end else if (busy) begin
                perr_d = 1'b1;
            end else if (state_q == S_UNINIT) begin
                if (!rs_q && data_q[7:5] == 3'b001) begin
                    init_d  = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end else begin
                    perr_d = 1'b1;
                end
            end else if (rs_q) begin
                mem_we  = 1'b1;
                mem_wa  = cur_idx;
                mem_wd  = data_q;
                ac_d    = ac_step(addr_counter, id_q);
                state_d = S_BUSY;
                cnt_d   = '0;
            end else begin
                state_d = S_BUSY;
                cnt_d   = '0;
                casez (data_q)
                    8'b1???_????: begin
                        if (data_q[6:4] == 3'b000 || data_q[6:4] == 3'b100) begin
                            ac_d = data_q[6:0];
                        end else begin
                            perr_d  = 1'b1;
                            state_d = state_q;
                            cnt_d   = cnt_q;
                        end
                    end
                    8'b0001_????: if (!data_q[3]) ac_d = ac_step(addr_counter, data_q[2]);
                    8'b0000_1???: begin
                        disp_d  = data_q[2];
                        curs_d  = data_q[1];
                        blink_d = data_q[0];
                    end
                    8'b0000_01??: id_d = data_q[1];
                    8'b0000_001?: ac_d = 7'h00;
                    8'b0000_0001: begin
                        state_d = S_CLEARING;
                        ac_d    = 7'h00;
                        id_d    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (host.E && host.RW) begin
            if (e_rise)    dout_d = host.RS ? (busy ? 8'h00 : ddram[cur_idx]) : {busy, addr_counter};
            else if (rs_q) dout_d = host.lcd_data_out;
            else           dout_d = {busy, addr_counter};
        end

        busy_d = (state_d == S_BUSY) || (state_d == S_CLEARING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_UNINIT;
            cnt_q             <= '0;
            e_d1              <= 1'b0;
            cap_v             <= 1'b0;
            rs_q              <= 1'b0;
            rw_q              <= 1'b0;
            data_q            <= 8'h00;
            addr_counter      <= 7'h00;
            id_q              <= 1'b1;
            initialized       <= 1'b0;
            display_on        <= 1'b0;
            cursor_on         <= 1'b0;
            blink_on          <= 1'b0;
            busy              <= 1'b0;
            protocol_err      <= 1'b0;
            host.lcd_data_oe  <= 1'b0;
            host.lcd_data_out <= 8'h00;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            e_d1              <= host.E;
            cap_v             <= cap_v_d;
            rs_q              <= rs_d;
            rw_q              <= rw_d;
            data_q            <= data_d;
            addr_counter      <= ac_d;
            id_q              <= id_d;
            initialized       <= init_d;
            display_on        <= disp_d;
            cursor_on         <= curs_d;
            blink_on          <= blink_d;
            busy              <= busy_d;
            protocol_err      <= perr_d;
            host.lcd_data_oe  <= oe_d;
            host.lcd_data_out <= dout_d;
        end
    end

    // DDRAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (mem_we) ddram[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_char <= 8'h00;
        else          rd_char <= ddram[rd_addr];
    end

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed bench for lcd_panel_responder with a strobe-level reference model
// and a per-cycle output comparator.
module tb_lcd_panel_responder;

    localparam int unsigned B = 4;
    localparam int unsigned C = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy, initialized, display_on, cursor_on, blink_on, protocol_err;
    logic [6:0] addr_counter;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;

    lcd_panel_responder_if bus ();

    lcd_panel_responder #(.BUSY_CYCLES(B), .CLEAR_CYCLES(C)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host         (bus),
        .busy         (busy),
        .initialized  (initialized),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .addr_counter (addr_counter),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    // Model: busy is "cycle index < busy_end", the error pulse lives on one cycle index
    int         busy_end;
    int         perr_cyc;
    logic       m_init, m_id, m_d, m_c, m_b;
    logic [6:0] m_ac;
    logic [7:0] m_ram [32];
    logic [7:0] exp_dread = 8'h00;
    logic       oe_exp_q = 1'b0;
    logic       rs_exp_q = 1'b0;
    logic [7:0] status_exp_q = 8'h00;

    function automatic logic m_busy(input int c);
        return c < busy_end;
    endfunction

    function automatic int pos_of(input logic [6:0] a);
        return int'(a[3:0]) + (a[6] ? 16 : 0);
    endfunction

    function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
        int p;
        logic [4:0] q;
        p = inc ? (pos_of(a) + 1) % 32 : (pos_of(a) + 31) % 32;
        q = 5'(p);
        return {q[4], 2'b00, q[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset;
        busy_end = 0;
        perr_cyc = -10;
        m_init   = 1'b0;
        m_id     = 1'b1;
        m_d      = 1'b0;
        m_c      = 1'b0;
        m_b      = 1'b0;
        m_ac     = 7'h00;
    endtask

    task automatic model_exec(input logic rs, input logic rw, input logic [7:0] d);
        int   n = cyc;
        logic was_busy;
        was_busy = m_busy(n - 1);
        if (rw) begin
            if (rs) begin
                if (m_init && !was_busy) m_ac = m_step(m_ac, m_id);
                else                     perr_cyc = n;
            end
        end else if (was_busy) begin
            perr_cyc = n;
        end else if (!m_init) begin
            if (!rs && d[7:5] == 3'b001) begin
                m_init = 1'b1;
                busy_end = n + B;
            end else begin
                perr_cyc = n;
            end
        end else if (rs) begin
            m_ram[pos_of(m_ac)] = d;
            m_ac = m_step(m_ac, m_id);
            busy_end = n + B;
        end else if (d[7]) begin
            if (d[6:0] <= 7'h0F || (d[6:0] >= 7'h40 && d[6:0] <= 7'h4F)) begin
                m_ac = d[6:0];
                busy_end = n + B;
            end else begin
                perr_cyc = n;
            end
        end else if (d[6] || d[5]) begin
            busy_end = n + B;
        end else if (d[4]) begin
            if (!d[3]) m_ac = m_step(m_ac, d[2]);
            busy_end = n + B;
        end else if (d[3]) begin
            m_d = d[2]; m_c = d[1]; m_b = d[0];
            busy_end = n + B;
        end else if (d[2]) begin
            m_id = d[1];
            busy_end = n + B;
        end else if (d[1]) begin
            m_ac = 7'h00;
            busy_end = n + B;
        end else if (d[0]) begin
            for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
            m_ac = 7'h00;
            m_id = 1'b1;
            busy_end = n + C;
        end else begin
            busy_end = n + B;
        end
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        oe_exp_q     <= bus.E & bus.RW;
        rs_exp_q     <= bus.RS;
        status_exp_q <= {m_busy(cyc), m_ac};
    end

    // Per-cycle comparison of all observable state against the model
    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            check("cyc_busy", busy, m_busy(cyc));
            check("cyc_init", initialized, m_init);
            check("cyc_flags", {display_on, cursor_on, blink_on}, {m_d, m_c, m_b});
            check("cyc_ac", addr_counter, m_ac);
            check("cyc_perr", protocol_err, cyc == perr_cyc);
            check("cyc_oe", bus.lcd_data_oe, oe_exp_q);
            check("cyc_dout", bus.lcd_data_out,
                  oe_exp_q ? (rs_exp_q ? exp_dread : status_exp_q) : 8'h00);
        end
    end

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    // All host tasks start 1 time unit after a rising edge and return likewise
    task automatic wr(input logic rs, input logic [7:0] d);
        #1;
        bus.RS = rs; bus.RW = 1'b0; bus.Data_Bus = d; bus.E = 1'b1;
        @(posedge clk);
        #2 bus.E = 1'b0;
        @(posedge clk);
        #1 model_exec(rs, 1'b0, d);
    endtask

    task automatic host_read(input logic rs, input int h, output logic [7:0] first_val);
        #1;
        bus.RS = rs; bus.RW = 1'b1; bus.E = 1'b1;
        exp_dread = m_busy(cyc) ? 8'h00 : m_ram[pos_of(m_ac)];
        @(negedge clk);
        @(negedge clk);
        first_val = bus.lcd_data_out;
        repeat (h - 1) @(negedge clk);
        bus.E = 1'b0;
        @(posedge clk);
        #1 model_exec(rs, 1'b1, 8'h00);
        bus.RW = 1'b0;
    endtask

    task automatic read_char(input int idx, output logic [7:0] v);
        rd_addr = 5'(idx);
        @(posedge clk);
        @(posedge clk);
        #1 v = rd_char;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_wait", busy, 1'b0);
        align();
    endtask

    task automatic cmd(input logic [7:0] d);
        wr(1'b0, d);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        bus.RS = 1'b0; bus.RW = 1'b0; bus.E = 1'b0; bus.Data_Bus = 8'h00;
        rd_addr = 5'd0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #11;
        check("rst_busy", busy, 1'b0);
        check("rst_init", initialized, 1'b0);
        check("rst_ac", addr_counter, 7'h00);
        check("rst_oe", bus.lcd_data_oe, 1'b0);
        check("rst_dout", bus.lcd_data_out, 8'h00);
        check("rst_rdchar", rd_char, 8'h00);
        check("rst_perr", protocol_err, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        align();

        // Clear before Function Set is refused
        wr(1'b0, 8'h01);
        @(negedge clk);
        check("preinit_perr", protocol_err, 1'b1);
        check("preinit_init", initialized, 1'b0);
        check("preinit_busy", busy, 1'b0);
        align();

        cmd(8'h38);
        cmd(8'h0C);
        cmd(8'h01);
        cmd(8'h06);
        check("init_flag", initialized, 1'b1);
        check("init_disp", display_on, 1'b1);
        check("init_curs", cursor_on, 1'b0);
        check("init_ac", addr_counter, 7'h00);
        for (int i = 0; i < 32; i++) begin
            read_char(i, v);
            check("clear_fill", v, 8'h20);
        end

        wr(1'b1, 8'h41); wait_idle();
        wr(1'b1, 8'h44); wait_idle();
        wr(1'b1, 8'h44); wait_idle();
        read_char(0, v); check("add_c0", v, 8'h41);
        read_char(1, v); check("add_c1", v, 8'h44);
        read_char(2, v); check("add_c2", v, 8'h44);
        check("add_ac", addr_counter, 7'h03);
        host_read(1'b0, 2, v);
        check("status_idle", v, 8'h03);
        @(negedge clk);
        check("oe_after_e", bus.lcd_data_oe, 1'b0);
        check("dout_after_e", bus.lcd_data_out, 8'h00);
        align();

        cmd(8'h8F);
        wr(1'b1, 8'h58); wait_idle();
        read_char(15, v); check("x_char", v, 8'h58);
        check("x_ac_wrap", addr_counter, 7'h40);
        cmd(8'hCF);
        wr(1'b1, 8'h59); wait_idle();
        check("y_ac_wrap", addr_counter, 7'h00);
        read_char(31, v); check("y_char", v, 8'h59);

        wr(1'b0, 8'h90);
        @(negedge clk);
        check("bad_addr_perr", protocol_err, 1'b1);
        check("bad_addr_busy", busy, 1'b0);
        check("bad_addr_ac", addr_counter, 7'h00);
        align();

        cmd(8'h04);
        cmd(8'h10);
        check("shift_left_wrap", addr_counter, 7'h4F);
        cmd(8'h14);
        check("shift_right_wrap", addr_counter, 7'h00);
        cmd(8'h06);
        cmd(8'h0F);
        check("dctl_flags", {display_on, cursor_on, blink_on}, 3'b111);

        cmd(8'h80);
        host_read(1'b1, 1, v);
        check("data_read", v, 8'h41);
        check("data_read_ac", addr_counter, 7'h01);

        // Back-to-back data strobes: the second lands while busy
        wr(1'b1, 8'h5A);
        wr(1'b1, 8'h51);
        host_read(1'b0, 1, v);
        check("status_busy", v, 8'h82);
        wait_idle();
        check("reject_ac", addr_counter, 7'h02);
        read_char(2, v); check("reject_ram", v, 8'h44);
        read_char(1, v); check("z_char", v, 8'h5A);

        // Reset in the middle of a clear
        wr(1'b0, 8'h01);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("midclr_busy", busy, 1'b0);
        check("midclr_init", initialized, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        align();
        wr(1'b1, 8'h41);
        @(negedge clk);
        check("post_rst_perr", protocol_err, 1'b1);
        check("post_rst_init", initialized, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        align();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
